countdown_timer: RTL

Time-entry and countdown engine for the microwave oven. It produces the three BCD digits that the 7-segment driver consumes: seconds_ones, seconds_tens and minutes (range 0:00 to 9:59).
- Keypad digits shift in from the right.
- Start, stop and pause/resume are handled here.
- The timer decrements once per second, derived from the system clock by an internal prescaler.
- A one-cycle done pulse is emitted on expiry.

---
 rtl/countdown_timer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Purpose : microwave time entry (BCD 0:00..9:59) and per-second countdown engine.
// Latency : outputs registered; digit/state changes visible one cycle after the causing edge.
// Backpr. : none; strobes are sampled every cycle and ignored when not applicable.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   digit_in     BCD keypad digit, qualified by digit_valid
//   digit_valid  one-cycle strobe for digit_in
//   start        one-cycle strobe: start from IDLE, resume from PAUSE
//   stop         one-cycle strobe: pause from RUN, clear from IDLE/PAUSE
//   seconds_ones BCD seconds units (0-9)
//   seconds_tens BCD seconds tens (0-5)
//   minutes      BCD minutes (0-9)
//   running      high while counting down
//   done         one-cycle pulse when the countdown reaches 0:00
module countdown_timer #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PRESC_W       = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] seconds_ones,
    output logic [3:0] seconds_tens,
    output logic [3:0] minutes,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [3:0]         so_q, so_d;
    logic [3:0]         st_q, st_d;
    logic [3:0]         mn_q, mn_d;
    logic               running_q;
    logic               done_q;

    logic time_zero;
    logic last_sec;
    logic tick;

    assign time_zero = (mn_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
    // The coming decrement lands on 0:00.
    assign last_sec  = (mn_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd1);
    assign tick      = (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        so_d    = so_q;
        st_d    = st_q;
        mn_d    = mn_q;

        case (state_q)
            S_IDLE: begin
                // stop > start > digit; a digit arriving with either strobe is dropped.
                if (stop) begin
                    so_d = 4'd0;
                    st_d = 4'd0;
                    mn_d = 4'd0;
                end else if (start) begin
                    if (!time_zero) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end else if (digit_valid && (digit_in <= 4'd9) && (so_q <= 4'd5)) begin
                    // Shift in from the right; a units digit above 5 would become an
                    // illegal tens digit, so such shifts are refused.
                    mn_d = st_q;
                    st_d = so_q;
                    so_d = digit_in;
                end
            end

            S_RUN: begin
                if (tick) begin
                    // The decrement applies even when stop arrives on the same edge.
                    presc_d = '0;
                    if (so_q != 4'd0) begin
                        so_d = so_q - 4'd1;
                    end else if (st_q != 4'd0) begin
                        so_d = 4'd9;
                        st_d = st_q - 4'd1;
                    end else begin
                        so_d = 4'd9;
                        st_d = 4'd5;
                        mn_d = mn_q - 4'd1;
                    end
                end else if (!stop) begin
                    presc_d = presc_q + PRESC_W'(1);
                end

                if (stop) begin
                    state_d = S_PAUSE;
                end else if (tick && last_sec) begin
                    state_d = S_DONE;
                end
            end

            S_PAUSE: begin
                if (stop) begin
                    so_d    = 4'd0;
                    st_d    = 4'd0;
                    mn_d    = 4'd0;
                    state_d = S_IDLE;
                end else if (start && !time_zero) begin
                    // A pause that landed on 0:00 cannot resume: counting from zero
                    // would underflow the minutes digit.
                    state_d = S_RUN;
                end
            end

            S_DONE: begin
                so_d    = 4'd0;
                st_d    = 4'd0;
                mn_d    = 4'd0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            so_q      <= 4'd0;
            st_q      <= 4'd0;
            mn_q      <= 4'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            so_q      <= so_d;
            st_q      <= st_d;
            mn_q      <= mn_d;
            // Status flags follow the state being entered so they line up with it.
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign seconds_ones = so_q;
    assign seconds_tens = st_q;
    assign minutes      = mn_q;
    assign running      = running_q;
    assign done         = done_q;

endmodule
